ysyx_22040125_if_id_skid: RTL and testbench
===========================================

# ysyx_22040125_if_id_skid

Parametrised IF/ID pipeline boundary register with a full valid/ready handshake and a two-entry skid buffer. It carries one fetched instruction and its PC from the fetch stage to decode, absorbs one beat of back-pressure without a combinational ready path from decode to fetch, squashes its contents on flush, and presents a NOP whenever no valid instruction is held. It also keeps a saturating count of decode-stall cycles for performance monitoring.

## Interface
Parameters:
- XLEN, 64, PC width in bits
- ILEN, 32, instruction width in bits
- NOP_INST, 32'h00000013, value driven on out_inst when out_valid=0 (addi x0,x0,0)
- RESET_PC, 0, reset value of out_pc
- CNT_W, 16, width of the stall counter

Ports:
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  synchronous, active-low reset
- flush  in  1  squash all held instructions this cycle
- in_valid  in  1  fetch presents a beat
- in_ready  out  1  block accepts a beat this cycle
- in_inst  in  ILEN  fetched instruction
- in_pc  in  XLEN  PC of in_inst
- out_valid  out  1  decode-side beat present
- out_ready  in  1  decode consumes the beat this cycle
- out_inst  out  ILEN  instruction to decode; NOP_INST when out_valid=0
- out_pc  out  XLEN  PC of out_inst
- occupancy  out  2  entries held (0, 1 or 2)
- stall_cycles  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0

## Operation
- Storage: main entry (m_valid, m_inst, m_pc) drives the outputs; skid entry (s_valid, s_inst, s_pc) holds the overflow beat.
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- in_ready = ~s_valid & ~flush (registered s_valid; the only combinational input is flush).
- out_valid = m_valid; out_inst = m_valid ? m_inst : NOP_INST; out_pc = m_pc (held value when invalid).
- occupancy = m_valid + s_valid; s_valid=1 implies m_valid=1 at all times.
- Priority per cycle: rst, then flush, then the data-movement rules.
- Data movement (no flush):
  - m empty, or out_fire with s empty: in_fire loads main; otherwise main empties on out_fire.
  - m full, no out_fire, in_fire: beat loads skid.
  - out_fire with s full: skid moves to main, skid empties (in_ready was 0, so there is no input).
  - No input and no out_fire: hold.
- Flush: m_valid and s_valid clear; m_pc and s_pc hold; no input is accepted (in_ready=0); an out_fire in the same cycle is still a completed transfer to decode.
- stall_cycles: +1 on each cycle with out_valid & ~out_ready, saturating at 2^CNT_W−1; not cleared by flush; cleared only by reset.
- Ordering: beats leave in acceptance order; no beat is duplicated or dropped except by flush.

## Timing
- Reset (rst=0 at an edge): m_valid=s_valid=0, out_inst=NOP_INST, out_pc=RESET_PC, occupancy=0, stall_cycles=0, in_ready=1 in the cycle after reset (if flush=0).
- Latency: a beat accepted at edge N appears on out_* after edge N (1 cycle) when the block is empty.
- Throughput: 1 beat per cycle while out_ready=1.
- Back-pressure: out_ready low for k≥1 cycles with a continuous input stream gives exactly one extra accepted beat. in_ready drops the cycle after the skid fills, and rises the cycle after the skid drains.
- Reset mid-operation overrides flush and all handshakes; held beats are lost.
- Flush and rst are both sampled synchronously; in_ready reacts to flush combinationally in the same cycle.

## Test plan
- Reset: hold rst=0 for 2 cycles with in_valid=1, then release. Required: out_valid=0, out_inst=32'h00000013, out_pc=RESET_PC, occupancy=0 and stall_cycles=0 during reset; in_ready=1 after release.
- Streaming: out_ready=1; send PC 0x1000, 0x1004 and 0x1008 on consecutive cycles. Required: each beat appears 1 cycle after acceptance, in order, with no bubbles.
- Skid: out_ready=0 for 3 cycles while in_valid=1 with PCs 0x2000, 0x2004, 0x2008. Required: 0x2000 and 0x2004 are accepted; in_ready=0 from the third cycle; occupancy=2; stall_cycles=3. After out_ready=1, the outputs are 0x2000 then 0x2004, then 0x2008 is accepted.
- Flush with the skid full: assert flush for one cycle with occupancy=2. Required: in_ready=0 during that cycle; next cycle out_valid=0, out_inst=NOP_INST, occupancy=0, out_pc unchanged, stall_cycles unchanged.
- Flush with out_fire: out_valid=1, out_ready=1, flush=1 and in_valid=1 (PC 0x3000). Required: the current beat counts as consumed; 0x3000 is not accepted; the block is empty next cycle.
- Counter saturation: set CNT_W=4 and hold out_valid=1 with out_ready=0 for 20 cycles. Required: stall_cycles stops at 15 and stays at 15.

Source files
------------

// File: rtl/ysyx_22040125_if_id_skid_if.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22040125_if_id_skid_if
// Description : Fetch-to-decode handshake bundle for the IF/ID skid register.
//               The master side is the environment (fetch + decode); the slave
//               side is the skid register itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface ysyx_22040125_if_id_skid_if #(
    parameter int XLEN  = 64,
    parameter int ILEN  = 32,
    parameter int CNT_W = 16
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [ILEN-1:0]  in_inst;
    logic [XLEN-1:0]  in_pc;
    logic             out_valid;
    logic             out_ready;
    logic [ILEN-1:0]  out_inst;
    logic [XLEN-1:0]  out_pc;
    logic [1:0]       occupancy;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output flush, in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_inst, out_pc, occupancy, stall_cycles
    );

    modport slave (
        input  flush, in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_inst, out_pc, occupancy, stall_cycles
    );
endinterface
`default_nettype wire

// File: rtl/ysyx_22040125_if_id_skid.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22040125_if_id_skid
// Description : IF/ID boundary register with valid/ready handshake and a
//               two-entry (main + skid) buffer. in_ready depends only on
//               registered state and flush, so decode back-pressure never
//               reaches fetch combinationally. Keeps a saturating count of
//               decode-stall cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22040125_if_id_skid #(
    parameter int              XLEN     = 64,
    parameter int              ILEN     = 32,
    parameter logic [ILEN-1:0] NOP_INST = 32'h00000013,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 16
) (
    input  wire                          clk,
    input  wire                          rst,
    ysyx_22040125_if_id_skid_if.slave    bus
);
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic             r_m_valid;
    logic [ILEN-1:0]  r_m_inst;
    logic [XLEN-1:0]  r_m_pc;
    logic             r_s_valid;
    logic [ILEN-1:0]  r_s_inst;
    logic [XLEN-1:0]  r_s_pc;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_in_ready;
    logic w_in_fire;
    logic w_out_fire;
    logic w_main_takes_input;

    // Handshake qualifiers; the skid being full is what throttles fetch.
    assign w_in_ready = ~r_s_valid & ~bus.flush;
    assign w_in_fire  = bus.in_valid & w_in_ready;
    assign w_out_fire = r_m_valid & bus.out_ready;
    // Main is free for a new beat when empty, or when it drains with no skid behind it.
    assign w_main_takes_input = ~r_m_valid | (w_out_fire & ~r_s_valid);

    // Main/skid entries: reset, then flush, then data movement.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_m_valid <= 1'b0;
            r_m_inst  <= NOP_INST;
            r_m_pc    <= RESET_PC;
            r_s_valid <= 1'b0;
            r_s_inst  <= NOP_INST;
            r_s_pc    <= RESET_PC;
        end else if (bus.flush) begin
            // PCs are deliberately kept so out_pc stays stable after a squash.
            r_m_valid <= 1'b0;
            r_s_valid <= 1'b0;
        end else if (w_main_takes_input) begin
            r_m_valid <= w_in_fire;
            if (w_in_fire) begin
                r_m_inst <= bus.in_inst;
                r_m_pc   <= bus.in_pc;
            end
        end else if (w_out_fire) begin
            // Main drains while skid is full: promote skid (no input possible).
            r_m_inst  <= r_s_inst;
            r_m_pc    <= r_s_pc;
            r_s_valid <= 1'b0;
        end else if (w_in_fire) begin
            r_s_valid <= 1'b1;
            r_s_inst  <= bus.in_inst;
            r_s_pc    <= bus.in_pc;
        end
    end

    // Saturating stall counter; survives flush, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (r_m_valid && !bus.out_ready && (r_stall_cnt != c_CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = r_m_valid;
    assign bus.out_inst     = r_m_valid ? r_m_inst : NOP_INST;
    assign bus.out_pc       = r_m_pc;
    assign bus.occupancy    = {1'b0, r_m_valid} + {1'b0, r_s_valid};
    assign bus.stall_cycles = r_stall_cnt;
endmodule
`default_nettype wire

// File: tb/tb_ysyx_22040125_if_id_skid.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_22040125_if_id_skid
// Description : Self-checking bench for the IF/ID skid register. A queue-based
//               model predicts every output each cycle; scripted scenarios pin
//               literal values. A second instance with a 4-bit counter checks
//               stall-counter saturation on the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_22040125_if_id_skid;
    localparam logic [31:0] c_NOP      = 32'h00000013;
    localparam logic [63:0] c_RESET_PC = 64'h0;

    logic clk;
    logic rst;

    ysyx_22040125_if_id_skid_if #(.XLEN(64), .ILEN(32), .CNT_W(16)) bus ();
    ysyx_22040125_if_id_skid_if #(.XLEN(64), .ILEN(32), .CNT_W(4))  bus4 ();

    ysyx_22040125_if_id_skid #(
        .XLEN(64), .ILEN(32), .NOP_INST(c_NOP), .RESET_PC(c_RESET_PC), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus.slave)
    );

    ysyx_22040125_if_id_skid #(
        .XLEN(64), .ILEN(32), .NOP_INST(c_NOP), .RESET_PC(c_RESET_PC), .CNT_W(4)
    ) dut4 (
        .clk(clk), .rst(rst), .bus(bus4.slave)
    );

    // The narrow-counter instance mirrors the main stimulus.
    assign bus4.flush     = bus.flush;
    assign bus4.in_valid  = bus.in_valid;
    assign bus4.in_inst   = bus.in_inst;
    assign bus4.in_pc     = bus.in_pc;
    assign bus4.out_ready = bus.out_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] inst_of(input logic [63:0] pc);
        return pc[31:0] ^ 32'hA5A5_0000;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [63:0] pc);
        bus.in_valid = v;
        bus.in_pc    = pc;
        bus.in_inst  = inst_of(pc);
    endtask

    // ---------------- behavioural model: FIFO of held beats ----------------
    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] pc;
    } beat_t;

    beat_t          mq[$];
    logic [63:0]    m_last_pc;
    longint         m_stalls;
    bit             m_ready;

    // Each negedge: compare DUT with model, then advance the model using the
    // inputs that the coming rising edge will sample.
    initial begin
        bit    out_fire;
        bit    in_fire;
        beat_t b;
        m_ready   = 1'b0;
        m_stalls  = 0;
        m_last_pc = c_RESET_PC;
        forever begin
            @(negedge clk);
            if (m_ready) begin
                check("in_ready", {63'b0, bus.in_ready},
                      {63'b0, (mq.size() < 2) && !bus.flush});
                check("out_valid", {63'b0, bus.out_valid}, {63'b0, mq.size() > 0});
                check("out_inst", {32'b0, bus.out_inst},
                      {32'b0, (mq.size() > 0) ? mq[0].inst : c_NOP});
                check("out_pc", bus.out_pc, (mq.size() > 0) ? mq[0].pc : m_last_pc);
                check("occupancy", {62'b0, bus.occupancy}, 64'(mq.size()));
                check("stall16", {48'b0, bus.stall_cycles},
                      (m_stalls > 65535) ? 64'd65535 : 64'(m_stalls));
                check("stall4", {60'b0, bus4.stall_cycles},
                      (m_stalls > 15) ? 64'd15 : 64'(m_stalls));
            end
            if (!rst) begin
                mq.delete();
                m_stalls  = 0;
                m_last_pc = c_RESET_PC;
                m_ready   = 1'b1;
            end else begin
                out_fire = (mq.size() > 0) && bus.out_ready;
                in_fire  = bus.in_valid && (mq.size() < 2) && !bus.flush;
                if ((mq.size() > 0) && !bus.out_ready) m_stalls++;
                if (bus.flush) begin
                    mq.delete();
                end else begin
                    if (out_fire) void'(mq.pop_front());
                    if (in_fire) begin
                        b.inst = bus.in_inst;
                        b.pc   = bus.in_pc;
                        mq.push_back(b);
                    end
                end
                if (mq.size() > 0) m_last_pc = mq[0].pc;
            end
        end
    end

    // ---------------- stimulus with literal expectations ----------------
    initial begin
        int mode;
        rst           = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        set_in(1'b1, 64'h9999);

        // Reset held for two edges with input offered.
        tick();
        tick();
        check("rst_out_valid", {63'b0, bus.out_valid}, 64'd0);
        check("rst_out_inst", {32'b0, bus.out_inst}, 64'h13);
        check("rst_out_pc", bus.out_pc, c_RESET_PC);
        check("rst_occupancy", {62'b0, bus.occupancy}, 64'd0);
        check("rst_stall", {48'b0, bus.stall_cycles}, 64'd0);
        rst = 1'b1;
        set_in(1'b0, 64'h0);
        #1;
        check("rst_in_ready", {63'b0, bus.in_ready}, 64'd1);

        // Streaming: one beat per cycle, one cycle latency.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 64'h1000 + 64'(4 * i));
            tick();
            check("stream_pc", bus.out_pc, 64'h1000 + 64'(4 * i));
            check("stream_inst", {32'b0, bus.out_inst}, {32'b0, inst_of(64'h1000 + 64'(4 * i))});
            check("stream_valid", {63'b0, bus.out_valid}, 64'd1);
        end
        set_in(1'b0, 64'h0);
        tick();
        check("stream_drain_valid", {63'b0, bus.out_valid}, 64'd0);
        check("stream_drain_inst", {32'b0, bus.out_inst}, 64'h13);
        check("stream_drain_pc", bus.out_pc, 64'h1008);

        // Skid: decode stalls while fetch keeps offering.
        bus.out_ready = 1'b0;
        set_in(1'b1, 64'h2000);
        tick();
        set_in(1'b1, 64'h2004);
        tick();
        set_in(1'b1, 64'h2008);
        #1;
        check("skid_in_ready_low", {63'b0, bus.in_ready}, 64'd0);
        tick();
        tick();
        check("skid_occupancy", {62'b0, bus.occupancy}, 64'd2);
        check("skid_stall", {48'b0, bus.stall_cycles}, 64'd3);
        check("skid_head_pc", bus.out_pc, 64'h2000);
        bus.out_ready = 1'b1;
        tick();
        check("skid_second_pc", bus.out_pc, 64'h2004);
        check("skid_second_occ", {62'b0, bus.occupancy}, 64'd1);
        check("skid_in_ready_back", {63'b0, bus.in_ready}, 64'd1);
        tick();
        check("skid_third_pc", bus.out_pc, 64'h2008);
        set_in(1'b0, 64'h0);
        tick();
        check("skid_empty", {62'b0, bus.occupancy}, 64'd0);
        check("skid_stall_kept", {48'b0, bus.stall_cycles}, 64'd3);

        // Flush with the skid full (decode ready during the flush cycle).
        bus.out_ready = 1'b0;
        set_in(1'b1, 64'h2100);
        tick();
        set_in(1'b1, 64'h2104);
        tick();
        check("fl_full_occ", {62'b0, bus.occupancy}, 64'd2);
        check("fl_full_stall", {48'b0, bus.stall_cycles}, 64'd4);
        bus.flush     = 1'b1;
        bus.out_ready = 1'b1;
        set_in(1'b1, 64'h2108);
        #1;
        check("fl_full_in_ready", {63'b0, bus.in_ready}, 64'd0);
        tick();
        check("fl_full_valid", {63'b0, bus.out_valid}, 64'd0);
        check("fl_full_inst", {32'b0, bus.out_inst}, 64'h13);
        check("fl_full_occ_after", {62'b0, bus.occupancy}, 64'd0);
        check("fl_full_pc_held", bus.out_pc, 64'h2100);
        check("fl_full_stall_kept", {48'b0, bus.stall_cycles}, 64'd4);

        // Flush concurrent with an output transfer and an offered input.
        bus.flush = 1'b0;
        set_in(1'b1, 64'h2200);
        tick();
        check("fl_fire_loaded", bus.out_pc, 64'h2200);
        bus.flush = 1'b1;
        set_in(1'b1, 64'h3000);
        #1;
        check("fl_fire_in_ready", {63'b0, bus.in_ready}, 64'd0);
        tick();
        check("fl_fire_valid", {63'b0, bus.out_valid}, 64'd0);
        check("fl_fire_occ", {62'b0, bus.occupancy}, 64'd0);
        check("fl_fire_pc", bus.out_pc, 64'h2200);
        bus.flush = 1'b0;
        set_in(1'b0, 64'h0);
        tick();
        check("fl_fire_still_empty", {62'b0, bus.occupancy}, 64'd0);

        // Counter saturation on the 4-bit instance (starts at 4).
        bus.out_ready = 1'b0;
        set_in(1'b1, 64'h4000);
        tick();
        set_in(1'b0, 64'h0);
        for (int i = 1; i <= 20; i++) begin
            tick();
            check("sat4", {60'b0, bus4.stall_cycles}, (4 + i > 15) ? 64'd15 : 64'(4 + i));
        end
        check("sat16", {48'b0, bus.stall_cycles}, 64'd24);

        // Randomized traffic; the model checks every cycle.
        mode = 0;
        for (int c = 0; c < 3000; c++) begin
            if ((c % 64) == 0) mode = int'($urandom_range(0, 3));
            rst           = ($urandom_range(0, 299) != 0);
            bus.flush     = ($urandom_range(0, 19) == 0);
            bus.in_valid  = (mode == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            bus.out_ready = (mode == 2) ? ($urandom_range(0, 3) == 0)
                          : (mode == 3) ? 1'b1 : ($urandom_range(0, 1) == 1);
            bus.in_inst   = $urandom;
            bus.in_pc     = {$urandom, $urandom};
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
